reg_bank_arbiter: RTL
=====================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 4, the data width of each bank register and write port.
REQ-002 The block SHALL have parameter N, default 4, fixed at 4 requesters and 4 bank registers; other values are unsupported.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-005 Port req, input, 4: req[i] high means requester i requests a write.
REQ-006 Port wdata, input, 4*W: requester i write data on bits [W*i+W-1 : W*i].
REQ-007 Port waddr, input, 8: requester i target register on bits [2i+1 : 2i].
REQ-008 Port clr, input, 1: synchronous clear of all bank registers.
REQ-009 Port gnt, output, 4: one-hot grant, combinational from req, clr and the round-robin pointer.
REQ-010 Port q_bank, output, 4*W: registered contents; register j on bits [W*j+W-1 : W*j].
REQ-011 Port raddr, input, 2: read select.
REQ-012 Port rdata, output, W: combinational read, equal to register raddr of q_bank.
REQ-013 Port wr_count, output, 8: registered count of completed writes.

Function
REQ-014 Internal state SHALL be 4 W-bit bank registers, a 2-bit round-robin pointer rr_ptr, and the 8-bit wr_count.
REQ-015 With clr low and any req bit high, gnt SHALL be one-hot at the first requester i with req[i] high, searching rr_ptr, rr_ptr+1, ... mod 4.
REQ-016 With req all zero or clr high, gnt SHALL be 4'b0000.
REQ-017 On a rising edge with gnt[i] high, bank register waddr[i] SHALL load wdata[i]; all other registers SHALL hold.
REQ-018 Write latency SHALL be one edge: q_bank and rdata reflect the write in the cycle after gnt[i] is high.
REQ-019 On a granted edge, rr_ptr SHALL become (i+1) mod 4, wrapping 3 to 0; it SHALL hold otherwise.
REQ-020 Handshake: requester i holds req, wdata and waddr stable until it samples gnt[i] high, then it may drop req or present a new request next cycle.
REQ-021 At most one write SHALL occur per cycle; requests to the same address from different requesters are serialized in grant order.
REQ-022 clr high SHALL zero all bank registers on the edge, take priority over any request, and leave rr_ptr and wr_count unchanged.
REQ-023 wr_count SHALL increment by 1 on every granted edge and saturate at 8'hFF.
REQ-024 rdata SHALL follow raddr combinationally with no added latency.

Reset
REQ-025 reset low SHALL asynchronously set all bank registers to 0, rr_ptr to 0, and wr_count to 0.
REQ-026 While reset is low, gnt SHALL be 0 and no write SHALL occur; gnt is evaluated from reset state after reset deasserts.
REQ-027 Reset asserted mid-stream SHALL discard any pending request with no partial write; requesters re-request after release.

Verification
REQ-028 Reset -> q_bank=0, wr_count=0, gnt=0; req=4'b0001, waddr[1:0]=2, wdata[3:0]=4'hA -> gnt=0001 same cycle; next cycle register 2 = 4'hA, rdata=4'hA with raddr=2, wr_count=1.
REQ-029 req=4'b1111 held for 4 cycles from rr_ptr=0 -> gnt sequence 0001, 0010, 0100, 1000; rr_ptr wraps to 0; wr_count=4.
REQ-030 rr_ptr=2, req=4'b0011 -> gnt=0001 (wrap search), then rr_ptr=1.
REQ-031 clr=1 with req=4'b0100 -> gnt=0, all registers 0 next cycle, rr_ptr and wr_count unchanged.
REQ-032 260 back-to-back grants -> wr_count stops at 8'hFF.
REQ-033 reset pulsed low between edges during a granted cycle -> registers, rr_ptr and wr_count are 0 immediately; the interrupted write never appears.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Four-register write bank shared by four requesters through a round-robin
// arbiter; one write per cycle, combinational read port, saturating write counter.
module reg_bank_arbiter #(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   input  logic [2*N-1:0] waddr,
   input  logic           clr,
   output logic [N-1:0]   gnt,
   output logic [N*W-1:0] q_bank,
   input  logic [1:0]     raddr,
   output logic [W-1:0]   rdata,
   output logic [7:0]     wr_count
);

   // Handshake: requester i keeps req[i], its wdata slice and its waddr slice
   // stable until it sees gnt[i] high; the write lands on that same rising edge.

   logic [W-1:0] bank_q [N];
   logic [W-1:0] bank_d [N];
   logic [W-1:0] wdata_a [N];
   logic [1:0]   waddr_a [N];
   logic [1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]   wr_count_q, wr_count_d;
   logic [1:0]   gnt_idx;
   logic [1:0]   scan_idx;
   logic         gnt_found;
   logic         gnt_any;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         wdata_a[i]          = wdata[W*i +: W];
         waddr_a[i]          = waddr[2*i +: 2];
         q_bank[W*i +: W]    = bank_q[i];
      end
   end

   // Search starts at rr_ptr and wraps, so the last winner gets lowest priority.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = rr_ptr_q;
      scan_idx  = rr_ptr_q;
      for (int k = 0; k < N; k++) begin
         scan_idx = rr_ptr_q + 2'(k);
         if (!gnt_found && req[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx;
         end
      end
      gnt_any = gnt_found && !clr && reset;
      gnt     = '0;
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   always_comb begin
      bank_d     = bank_q;
      rr_ptr_d   = rr_ptr_q;
      wr_count_d = wr_count_q;
      if (clr) begin
         for (int i = 0; i < N; i++) bank_d[i] = '0;
      end else if (gnt_any) begin
         bank_d[waddr_a[gnt_idx]] = wdata_a[gnt_idx];
         rr_ptr_d                 = gnt_idx + 2'd1;
         if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) bank_q[i] <= '0;
         rr_ptr_q   <= 2'd0;
         wr_count_q <= 8'd0;
      end else begin
         for (int i = 0; i < N; i++) bank_q[i] <= bank_d[i];
         rr_ptr_q   <= rr_ptr_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rdata    = bank_q[raddr];
   assign wr_count = wr_count_q;

endmodule
